// File: rtl/conv_lane_array.sv
// rtl/conv_lane_array.sv - multi-lane MAC engine: one neuron broadcast per cycle, per-lane dot products
// Optional feature macro: CONV_LANE_SATURATE_EN (saturating accumulate with sticky overflow)
module conv_lane_array #(
  parameter int DATA_BUS_BIT_WIDTH = 32,
  parameter int FUNCTION_BIT_WIDTH = 4,
  parameter int NUM_LANES          = 4,
  parameter int NEURON_WIDTH       = 8,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int MAX_FILTER_SIZE    = 64,
  parameter int ACC_WIDTH          = 24
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            layer_reset,
  input  logic [DATA_BUS_BIT_WIDTH-1:0]   data_bus,
  input  logic [FUNCTION_BIT_WIDTH-1:0]   function_sel,
  output logic [NUM_LANES*ACC_WIDTH-1:0]  results,
  output logic                            result_valid,
  output logic                            weights_loaded,
  output logic                            seq_error,
  output logic                            overflow
);

  localparam int TAP_W  = (MAX_FILTER_SIZE > 1) ? $clog2(MAX_FILTER_SIZE) : 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = $clog2(NUM_LANES + 1);
  localparam int PROD_W = NEURON_WIDTH + WEIGHT_WIDTH;

  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_SIZE    = FUNCTION_BIT_WIDTH'(2);
  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_NUM     = FUNCTION_BIT_WIDTH'(5);
  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_WEIGHT  = FUNCTION_BIT_WIDTH'(7);
  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_NEURON  = FUNCTION_BIT_WIDTH'(9);
  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_NEUR_OP = FUNCTION_BIT_WIDTH'(10);
  localparam logic [FUNCTION_BIT_WIDTH-1:0] FN_OP      = FUNCTION_BIT_WIDTH'(11);

  typedef enum logic [1:0] {CONFIG, LOADING, READY, COMPUTING} state_t;

  state_t                          state, state_next;
  logic [TAP_W-1:0]                size_m1;
  logic [CNT_W-1:0]                active;
  logic [TAP_W-1:0]                wr_tap, op_tap;
  logic [LANE_W-1:0]               wr_lane;
  logic signed [NEURON_WIDTH-1:0]  neuron;
  logic signed [WEIGHT_WIDTH-1:0]  weights [NUM_LANES][MAX_FILTER_SIZE];
  logic signed [ACC_WIDTH-1:0]     acc     [NUM_LANES];
  logic signed [ACC_WIDTH-1:0]     sum     [NUM_LANES];
  logic signed [PROD_W-1:0]        prod    [NUM_LANES];
  logic signed [ACC_WIDTH:0]       wide    [NUM_LANES];
  logic [NUM_LANES-1:0]            lane_on;
  logic [NUM_LANES-1:0]            clip;

  logic is_cfg, is_wr, is_op, loads_neuron, armed, mac_en, last_tap, last_wr;

  assign is_cfg       = (function_sel == FN_SIZE) || (function_sel == FN_NUM);
  assign is_wr        = (function_sel == FN_WEIGHT);
  assign is_op        = (function_sel == FN_OP) || (function_sel == FN_NEUR_OP);
  assign loads_neuron = (function_sel == FN_NEURON) || (function_sel == FN_NEUR_OP);
  assign armed        = (state == READY) || (state == COMPUTING);
  assign mac_en       = is_op && armed;
  assign last_tap     = (op_tap == size_m1);
  assign last_wr      = is_wr && (wr_tap == size_m1) && (int'(wr_lane) == int'(active) - 1);

`ifdef CONV_LANE_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  // One extra bit on the add exposes overflow for the clamp; in wrap mode it is simply dropped.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_on[l] = (l < int'(active));
      prod[l]    = neuron * weights[l][op_tap];
      wide[l]    = (ACC_WIDTH+1)'(acc[l]) + (ACC_WIDTH+1)'(prod[l]);
      clip[l]    = 1'b0;
      sum[l]     = wide[l][ACC_WIDTH-1:0];
`ifdef CONV_LANE_SATURATE_EN
      if (wide[l][ACC_WIDTH] != wide[l][ACC_WIDTH-1]) begin
        clip[l] = 1'b1;
        sum[l]  = wide[l][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    if (layer_reset || is_cfg) begin
      state_next = CONFIG;
    end else begin
      case (state)
        CONFIG, LOADING: if (is_wr) state_next = last_wr ? READY : LOADING;
        READY:           if (mac_en && !last_tap) state_next = COMPUTING;
        COMPUTING:       if (mac_en && last_tap) state_next = READY;
        default:         state_next = CONFIG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= CONFIG;
      size_m1        <= '0;
      active         <= CNT_W'(1);
      wr_tap         <= '0;
      wr_lane        <= '0;
      op_tap         <= '0;
      neuron         <= '0;
      results        <= '0;
      result_valid   <= 1'b0;
      weights_loaded <= 1'b0;
      seq_error      <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        acc[l] <= '0;
        for (int t = 0; t < MAX_FILTER_SIZE; t++) weights[l][t] <= '0;
      end
    end else begin
      state          <= state_next;
      weights_loaded <= (state_next == READY) || (state_next == COMPUTING);
      result_valid   <= 1'b0;
      if (layer_reset) begin
        wr_tap    <= '0;
        wr_lane   <= '0;
        op_tap    <= '0;
        results   <= '0;
        seq_error <= 1'b0;
        for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
      end else begin
        if (is_cfg) begin
          wr_tap  <= '0;
          wr_lane <= '0;
          op_tap  <= '0;
          for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
          if (function_sel == FN_SIZE) begin
            if (data_bus > DATA_BUS_BIT_WIDTH'(MAX_FILTER_SIZE - 1)) size_m1 <= TAP_W'(MAX_FILTER_SIZE - 1);
            else size_m1 <= data_bus[TAP_W-1:0];
          end else begin
            if (data_bus == '0) active <= CNT_W'(1);
            else if (data_bus > DATA_BUS_BIT_WIDTH'(NUM_LANES)) active <= CNT_W'(NUM_LANES);
            else active <= data_bus[CNT_W-1:0];
          end
        end
        if (is_wr) begin
          weights[wr_lane][wr_tap] <= data_bus[WEIGHT_WIDTH-1:0];
          if (wr_tap == size_m1) begin
            wr_tap  <= '0;
            wr_lane <= last_wr ? '0 : wr_lane + 1'b1;
          end else begin
            wr_tap <= wr_tap + 1'b1;
          end
        end
        if (loads_neuron) neuron <= data_bus[NEURON_WIDTH-1:0];
        if (is_op && !armed) seq_error <= 1'b1;
        if (mac_en) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (last_tap) begin
              results[l*ACC_WIDTH +: ACC_WIDTH] <= lane_on[l] ? sum[l] : '0;
              acc[l] <= '0;
            end else begin
              acc[l] <= lane_on[l] ? sum[l] : '0;
            end
          end
          op_tap       <= last_tap ? '0 : op_tap + 1'b1;
          result_valid <= last_tap;
        end
      end
    end
  end

`ifdef CONV_LANE_SATURATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (layer_reset) overflow <= 1'b0;
    else if (mac_en && |(clip & lane_on)) overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
  logic unused_clip;
  assign unused_clip = ^clip;
`endif

endmodule

// File: tb/tb_conv_lane_array.sv
// tb/tb_conv_lane_array.sv - directed self-checking bench for conv_lane_array
// Overflow expectations follow CONV_LANE_SATURATE_EN.
module tb_conv_lane_array;
  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        reset, layer_reset;
  logic [31:0] data_bus;
  logic [3:0]  function_sel;
  logic [4*AW-1:0] results;
  logic        result_valid, weights_loaded, seq_error, overflow;

  int errors = 0;
  int checks = 0;
  int pulses;
  int pidx [2];

  conv_lane_array #(.ACC_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .layer_reset(layer_reset), .data_bus(data_bus),
    .function_sel(function_sel), .results(results), .result_valid(result_valid),
    .weights_loaded(weights_loaded), .seq_error(seq_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [AW-1:0] lane(input int i);
    return results[i*AW +: AW];
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] f, input logic [31:0] d);
    function_sel = f;
    data_bus     = d;
    @(negedge clk);
  endtask

  task automatic lrst();
    layer_reset  = 1'b1;
    function_sel = 4'd0;
    @(negedge clk);
    layer_reset  = 1'b0;
  endtask

  // 9-tap window on 3 lanes; weights_loaded must rise on exactly the 27th write
  task automatic load_win(input int w0, input int w1, input int w2);
    int wv;
    for (int l = 0; l < 3; l++) begin
      wv = (l == 0) ? w0 : (l == 1) ? w1 : w2;
      for (int t = 0; t < 9; t++) begin
        if (l == 2 && t == 8) check("wl_before_last", 32'(weights_loaded), 0);
        step(4'd7, 32'(wv));
      end
    end
    check("wl_after_last", 32'(weights_loaded), 1);
  endtask

  task automatic run_ops(input logic [3:0] f, input logic [31:0] d, input int n, input int exp_lane0);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(f, d);
      if (result_valid) begin
        if (pulses < 2) pidx[pulses] = i;
        pulses++;
        check("pulse_lane0", 32'(lane(0)), exp_lane0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; layer_reset = 1'b0; data_bus = '0; function_sel = '0;
    repeat (2) @(negedge clk);
    check("rst_results", 32'(results), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_wl", 32'(weights_loaded), 0);
    check("rst_seq", 32'(seq_error), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    // Window math: 9 taps, 3 filters, neuron 3
    step(4'd2, 32'd8);
    step(4'd5, 32'd3);
    load_win(1, 2, -1);
    step(4'd9, 32'd3);
    run_ops(4'd10, 32'd3, 9, 27);
    check("win_pulses", pulses, 1);
    check("win_pulse_at", pidx[0], 8);
    check("win_lane1", 32'(lane(1)), 54);
    check("win_lane2", 32'(lane(2)), -27);
    check("win_lane3", 32'(lane(3)), 0);
    step(4'd0, 32'd0);
    check("win_valid_drop", 32'(result_valid), 0);
    check("win_hold", 32'(lane(0)), 27);

    // Back-to-back windows with neuron 1
    step(4'd9, 32'd1);
    run_ops(4'd11, 32'd0, 18, 9);
    check("b2b_pulses", pulses, 2);
    check("b2b_first", pidx[0], 8);
    check("b2b_period", pidx[1] - pidx[0], 9);
    check("b2b_lane1", 32'(lane(1)), 18);
    check("b2b_lane2", 32'(lane(2)), -9);

    // Overflow: 64 taps of 127*127 on one lane
    step(4'd2, 32'd63);
    step(4'd5, 32'd1);
    check("ovf_wl_cleared", 32'(weights_loaded), 0);
    for (int i = 0; i < 64; i++) step(4'd7, 32'd127);
    check("ovf_wl", 32'(weights_loaded), 1);
    step(4'd9, 32'd127);
`ifdef CONV_LANE_SATURATE_EN
    run_ops(4'd11, 32'd0, 64, 32767);
    check("ovf_flag", 32'(overflow), 1);
`else
    run_ops(4'd11, 32'd0, 64, -16320);
    check("ovf_flag", 32'(overflow), 0);
`endif
    check("ovf_pulses", pulses, 1);
    check("ovf_lane1_inactive", 32'(lane(1)), 0);

    // Sequencing error and config retention across layer_reset
    lrst();
    check("lr_ovf", 32'(overflow), 0);
    check("lr_wl", 32'(weights_loaded), 0);
    check("lr_results", 32'(results), 0);
    run_ops(4'd11, 32'd0, 3, 0);
    check("seq_no_pulse", pulses, 0);
    check("seq_err_set", 32'(seq_error), 1);
    lrst();
    check("seq_err_clr", 32'(seq_error), 0);
    for (int i = 0; i < 63; i++) step(4'd7, 32'd1);
    check("keep_cfg_63", 32'(weights_loaded), 0);
    step(4'd7, 32'd1);
    check("keep_cfg_64", 32'(weights_loaded), 1);

    // Mid-window layer_reset, issued together with an operand fetch
    step(4'd2, 32'd8);
    step(4'd5, 32'd3);
    load_win(1, 2, -1);
    step(4'd9, 32'd2);
    run_ops(4'd11, 32'd0, 4, 0);
    check("mid_no_pulse", pulses, 0);
    layer_reset = 1'b1; function_sel = 4'd11; data_bus = '0;
    @(negedge clk);
    layer_reset = 1'b0;
    check("mid_wl", 32'(weights_loaded), 0);
    check("mid_valid", 32'(result_valid), 0);
    check("mid_seq", 32'(seq_error), 0);
    load_win(1, 2, -1);
    step(4'd9, 32'd2);
    run_ops(4'd11, 32'd0, 9, 18);
    check("mid_pulses", pulses, 1);
    check("mid_lane1", 32'(lane(1)), 36);
    check("mid_lane2", 32'(lane(2)), -18);

    // Asynchronous reset mid-window
    run_ops(4'd11, 32'd0, 3, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_results", 32'(results), 0);
    check("arst_wl", 32'(weights_loaded), 0);
    check("arst_valid", 32'(result_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    step(4'd7, 32'd5);
    check("arst_cfg_wl", 32'(weights_loaded), 1);
    step(4'd9, 32'd3);
    step(4'd11, 32'd0);
    check("arst_cfg_valid", 32'(result_valid), 1);
    check("arst_cfg_lane0", 32'(lane(0)), 15);
    check("arst_cfg_lane1", 32'(lane(1)), 0);
    step(4'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_lane_array.md
# conv_lane_array

Parametrised multi-lane MAC engine; successor to the fixed quad computation unit, and driven by the same `data_bus` / `function_sel` command stream. Holds up to `NUM_LANES` filters of up to `MAX_FILTER_SIZE` taps each. Broadcasts one neuron per cycle to all lanes and accumulates per-lane dot products. It emits a registered result vector with a one-cycle valid pulse at the end of every filter window. It sits between the layer controller (command source) and the activation/pooling stage (result sink).

## Interface
- `DATA_BUS_BIT_WIDTH`, 32, command/data bus width
- `FUNCTION_BIT_WIDTH`, 4, function code width
- `NUM_LANES`, 4, parallel filters (≥1)
- `NEURON_WIDTH`, 8, signed neuron width
- `WEIGHT_WIDTH`, 8, signed weight width
- `MAX_FILTER_SIZE`, 64, taps per filter (power of 2)
- `ACC_WIDTH`, 24, signed accumulator/result width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state including config
- `layer_reset`  in  1  synchronous; clears counters, accumulators, results, flags, weights_loaded; keeps config
- `data_bus`  in  DATA_BUS_BIT_WIDTH  command payload
- `function_sel`  in  FUNCTION_BIT_WIDTH  command code
- `results`  out  NUM_LANES*ACC_WIDTH  lane i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- `result_valid`  out  1  one-cycle pulse, results updated
- `weights_loaded`  out  1  all active weights written
- `seq_error`  out  1  sticky: operand fetch before weights_loaded
- `overflow`  out  1  sticky saturation flag (see Configuration)

## Operation
- Function codes: 0 NO_FUNCTION, 2 FETCH_FILTER_SIZE, 5 FETCH_NUM_OF_FILTERS, 7 FETCH_FILTER_WEIGHT, 9 NEURON_FETCH, 10 NEURON_FETCH_AND_OPERAND_FETCH, 11 OPERAND_FETCH; 1, 3, 4, 6, 8 and 12-15 are no-ops here.
- FETCH_FILTER_SIZE: `size_m1 = min(data_bus, MAX_FILTER_SIZE-1)`; window = size_m1+1 taps.
- FETCH_NUM_OF_FILTERS: `active = clamp(data_bus, 1, NUM_LANES)`. Lanes ≥ active never accumulate; they output 0.
- Codes 2 and 5 also clear tap/lane counters, accumulators and weights_loaded.
- FETCH_FILTER_WEIGHT: `weight[lane][tap] <= data_bus[WEIGHT_WIDTH-1:0]`. Tap increments; on size_m1 it wraps to 0 and lane increments. The write with lane = active-1 and tap = size_m1 sets weights_loaded. Further writes wrap to lane 0 and overwrite.
- NEURON_FETCH: `neuron <= data_bus[NEURON_WIDTH-1:0]`.
- OPERAND_FETCH (when weights_loaded): each active lane computes `acc += neuron * weight[lane][tap]`, full signed product sign-extended to ACC_WIDTH, and op_tap increments.
- At op_tap = size_m1: `results <= acc + product` (final tap included), result_valid pulses, acc restarts from 0 next op, op_tap wraps to 0.
- NEURON_FETCH_AND_OPERAND_FETCH: the MAC uses the neuron held before this edge; the neuron register loads data_bus at the same edge.
- OPERAND_FETCH or code 10 while !weights_loaded: no MAC, counters unchanged, seq_error set. Code 10 still loads the neuron.
- State: CONFIG (after reset/layer_reset/codes 2,5) → LOADING (first weight write) → READY (weights_loaded) → COMPUTING (op_tap ≠ 0) → READY on window end. layer_reset from any state → CONFIG.

## Timing
- Reset values: results 0, result_valid 0, weights_loaded 0, seq_error 0, overflow 0. Config after reset: size_m1 = 0, active = 1.
- All outputs registered. result_valid is high in the cycle after the edge that sampled the final tap, for exactly one cycle.
- Back-to-back windows are allowed without gaps; the valid pulse period equals the window length.
- results hold between pulses; they are cleared only by reset or layer_reset.
- layer_reset has priority over function_sel in the same cycle. Asserting reset mid-window discards the partial sums.

## Configuration
- `CONV_LANE_SATURATE_EN` defined: the accumulator and the result add clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]; any clamp sets overflow (sticky until reset/layer_reset).
- Not defined: two's-complement wrap, and overflow is tied 0.

## Test plan
- Reset: pulse reset mid-run -> all outputs 0 asynchronously; config returns to size 1, active 1.
- Window math (NUM_LANES=4): size bus 8, filters bus 3, 27 weight writes (lane0 = 1, lane1 = 2, lane2 = −1). Then NEURON_FETCH 3 followed by 9×code 10 with bus 3 -> weights_loaded after 27th write; one pulse with results {0, −27, 54, 27} (lane3..lane0).
- Back-to-back: same weights, neuron 1, 18×OPERAND_FETCH -> two pulses 9 cycles apart, lane0 = 9 each time (no carry-over).
- Overflow (ACC_WIDTH=16): size bus 63, 1 filter, weights 127, neuron 127, 64 ops -> with macro lane0 = 32767 and overflow = 1; without macro lane0 = −16320 and overflow = 0.
- Sequencing: OPERAND_FETCH before any weight write -> no pulse, seq_error = 1; layer_reset -> seq_error = 0, config retained.
- Mid-window layer_reset: after 4 of 9 taps -> weights_loaded = 0; after reloading weights, the next 9 ops produce clean results with no residue from the aborted window.
